// File: rtl/sbb_pkg.sv
// Shared defaults and read-FSM state encoding for symbol_bank_buffer.
// SYMBOL_BANK_ZERO_PAD_EN adds the PAD state used for zero padding.
package sbb_pkg;

    localparam int SBB_DATA_WIDTH = 18;
    localparam int SBB_DEPTH      = 1200;
    localparam int SBB_NUM_BANKS  = 2;
    localparam int SBB_PAD_LEN    = 2048;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1
`ifdef SYMBOL_BANK_ZERO_PAD_EN
        , ST_PAD = 2'd2
`endif
    } rd_state_e;

endpackage

// File: rtl/sbb_bank_ram.sv
// One symbol bank: simple dual-port RAM, one write port and one registered read port.
module sbb_bank_ram
    import sbb_pkg::*;
#(
    parameter int DATA_WIDTH = SBB_DATA_WIDTH,
    parameter int DEPTH      = SBB_DEPTH
)(
    input  logic                          CLK,
    input  logic                          we,
    input  logic [$clog2(DEPTH)-1:0]      waddr,
    input  logic signed [DATA_WIDTH-1:0]  wdata,
    input  logic                          re,
    input  logic [$clog2(DEPTH)-1:0]      raddr,
    output logic signed [DATA_WIDTH-1:0]  rdata
);

    logic signed [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Storage is never reset; the read register only moves when re is high.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/symbol_bank_buffer.sv
// Multi-bank symbol buffer: writes fill one bank per symbol, reads stream committed banks in order.
// SYMBOL_BANK_ZERO_PAD_EN pads every symbol with zeros up to PAD_LEN beats.
module symbol_bank_buffer
    import sbb_pkg::*;
#(
    parameter int DATA_WIDTH = SBB_DATA_WIDTH,
    parameter int DEPTH      = SBB_DEPTH,
    parameter int NUM_BANKS  = SBB_NUM_BANKS,
    parameter int PAD_LEN    = SBB_PAD_LEN
)(
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                wr_valid,
    input  logic [$clog2(DEPTH)-1:0]            wr_addr,
    input  logic signed [DATA_WIDTH-1:0]        wr_data,
    input  logic                                wr_last,
    output logic                                wr_ready,
    output logic                                rd_valid,
    input  logic                                rd_ready,
    output logic signed [DATA_WIDTH-1:0]        rd_data,
    output logic                                rd_last,
    output logic [$clog2(NUM_BANKS+1)-1:0]      occupancy,
    output logic                                addr_err
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = $clog2(NUM_BANKS);
    localparam int OCC_W  = $clog2(NUM_BANKS+1);
    localparam int LEN_W  = $clog2(DEPTH+1);
    localparam int IDX_W  = $clog2(PAD_LEN);
    localparam int CMP_W  = IDX_W + LEN_W;

    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r, fetch_ptr_r;
    logic [OCC_W-1:0]   occupancy_r;
    logic               addr_err_r;
    logic [LEN_W-1:0]   len_r [NUM_BANKS];
    rd_state_e          state_r, state_nxt_s;
    logic [IDX_W-1:0]   fi_r;
    logic               rd_valid_r, rd_last_r, rd_zero_r;

    logic               wr_fire_s, in_range_s, commit_s, release_s;
    logic [LEN_W-1:0]   commit_len_s;
    logic               load_s, pending_s, avail_s, have_s, pad_s, fire_s;
    logic               last_data_s, beat_last_s;
    logic [IDX_W-1:0]   idx_s;
    logic signed [DATA_WIDTH-1:0] ram_q_s [NUM_BANKS];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(NUM_BANKS-1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Write-side decode: acceptance, range check and the length a closing beat commits.
    always_comb begin
        wr_fire_s  = wr_valid && wr_ready;
        in_range_s = 32'(wr_addr) < 32'(DEPTH);
        commit_s   = wr_fire_s && wr_last;
        release_s  = rd_valid_r && rd_ready && rd_last_r;
        if (in_range_s) begin
            commit_len_s = LEN_W'(wr_addr) + LEN_W'(1);
        end else begin
            commit_len_s = LEN_W'(DEPTH);
        end
    end

    // Bank bookkeeping: pointers, per-bank lengths, occupancy and the sticky range error.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            occupancy_r <= '0;
            addr_err_r  <= 1'b0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                len_r[i] <= '0;
            end
        end else begin
            if (wr_fire_s && !in_range_s) begin
                addr_err_r <= 1'b1;
            end
            if (commit_s) begin
                len_r[wr_ptr_r] <= commit_len_s;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (release_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            if (commit_s && !release_s) begin
                occupancy_r <= occupancy_r + OCC_W'(1);
            end else if (release_s && !commit_s) begin
                occupancy_r <= occupancy_r - OCC_W'(1);
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Fetch decode: which beat (if any) loads into the output stage this cycle.
    // A bank whose last beat still sits unaccepted in the output stage is not yet available again.
    always_comb begin
        load_s    = !rd_valid_r || rd_ready;
        pending_s = rd_valid_r && rd_last_r;
        avail_s   = occupancy_r > (pending_s ? OCC_W'(1) : OCC_W'(0));
        have_s    = 1'b0;
        pad_s     = 1'b0;
        idx_s     = '0;
        case (state_r)
            ST_IDLE: have_s = avail_s;
            ST_READ: begin
                have_s = 1'b1;
                idx_s  = fi_r;
            end
`ifdef SYMBOL_BANK_ZERO_PAD_EN
            ST_PAD: begin
                have_s = 1'b1;
                pad_s  = 1'b1;
                idx_s  = fi_r;
            end
`endif
            default: have_s = 1'b0;
        endcase
        last_data_s = (CMP_W'(idx_s) + CMP_W'(1)) == CMP_W'(len_r[fetch_ptr_r]);
`ifdef SYMBOL_BANK_ZERO_PAD_EN
        beat_last_s = idx_s == IDX_W'(PAD_LEN-1);
`else
        beat_last_s = last_data_s;
`endif
        fire_s = load_s && have_s;
    end

    // Read FSM next state; IDLE loads beat 0 itself so banks stream without a bubble.
    always_comb begin
        state_nxt_s = state_r;
        if (fire_s) begin
            if (beat_last_s) begin
                state_nxt_s = ST_IDLE;
            end
`ifdef SYMBOL_BANK_ZERO_PAD_EN
            else if (last_data_s && !pad_s) begin
                state_nxt_s = ST_PAD;
            end
`endif
            else begin
                state_nxt_s = ST_READ;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Output stage and fetch position; everything holds while the beat is stalled.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            fi_r        <= '0;
            fetch_ptr_r <= '0;
            rd_valid_r  <= 1'b0;
            rd_last_r   <= 1'b0;
            rd_zero_r   <= 1'b1;
        end else begin
            if (fire_s) begin
                fi_r <= beat_last_s ? '0 : idx_s + IDX_W'(1);
                if (beat_last_s) begin
                    fetch_ptr_r <= ptr_inc(fetch_ptr_r);
                end
            end
            if (load_s) begin
                rd_valid_r <= have_s;
                rd_last_r  <= have_s && beat_last_s;
                if (have_s) begin
                    rd_zero_r <= pad_s;
                end
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        sbb_bank_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_ram (
            .CLK   (CLK),
            .we    (wr_fire_s && in_range_s && (wr_ptr_r == PTR_W'(b))),
            .waddr (wr_addr),
            .wdata (wr_data),
            .re    (fire_s && !pad_s && (fetch_ptr_r == PTR_W'(b))),
            .raddr (idx_s[ADDR_W-1:0]),
            .rdata (ram_q_s[b])
        );
    end

    // The beat on the output always belongs to the oldest unreleased bank.
    assign rd_data   = rd_zero_r ? '0 : ram_q_s[rd_ptr_r];
    assign rd_valid  = rd_valid_r;
    assign rd_last   = rd_last_r;
    assign occupancy = occupancy_r;
    assign addr_err  = addr_err_r;
    assign wr_ready  = occupancy_r < OCC_W'(NUM_BANKS);

endmodule

// File: doc/symbol_bank_buffer.md
SYMBOL_BANK_BUFFER -- requirements
Module: symbol_bank_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 18, meaning the width of one stored sample.
REQ-002 SHALL have parameter DEPTH, default 1200, meaning the maximum samples per symbol.
REQ-003 SHALL have parameter NUM_BANKS, default 2 (legal 2..8), meaning the number of symbol banks.
REQ-004 SHALL have parameter PAD_LEN, default 2048, meaning the padded output length (>= DEPTH).
REQ-005 SHALL have port CLK  in  1  clock; all logic is rising-edge.
REQ-006 SHALL have port RST  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port wr_valid  in  1  write beat present.
REQ-008 SHALL have port wr_addr  in  ADDR_W  0-based sample index; ADDR_W = clog2(DEPTH).
REQ-009 SHALL have port wr_data  in  DATA_WIDTH  signed sample.
REQ-010 SHALL have port wr_last  in  1  closes the symbol; length = wr_addr+1.
REQ-011 SHALL have port wr_ready  out  1  a free bank is open for writing.
REQ-012 SHALL have port rd_valid  out  1  rd_data valid.
REQ-013 SHALL have port rd_ready  in  1  downstream (FFT) accepts the beat.
REQ-014 SHALL have port rd_data  out  DATA_WIDTH  output sample.
REQ-015 SHALL have port rd_last  out  1  final beat of the symbol.
REQ-016 SHALL have port occupancy  out  clog2(NUM_BANKS+1)  number of committed unread banks.
REQ-017 SHALL have port addr_err  out  1  sticky flag for an out-of-range write.

Function
REQ-018 Write beat SHALL occur when wr_valid && wr_ready and store wr_data at bank[wr_ptr][wr_addr].
REQ-019 Writes with wr_addr >= DEPTH SHALL be dropped and SHALL set addr_err, which stays set until reset; a dropped beat carrying wr_last still commits, with length DEPTH.
REQ-020 A write beat with wr_last SHALL latch the length into len[wr_ptr], advance wr_ptr modulo NUM_BANKS and increment occupancy.
REQ-021 wr_ready SHALL equal (occupancy < NUM_BANKS) and be combinational from registered state only.
REQ-022 Read FSM SHALL have states IDLE, READ, PAD; IDLE->READ when occupancy > 0; READ->PAD on accepting the beat at index len-1 when padding is enabled, else READ->IDLE (or READ again if another bank is committed).
REQ-023 Read latency SHALL be 1 cycle from the bank becoming committed to rd_valid asserting; output registers SHALL load only when !rd_valid || rd_ready.
REQ-024 rd_data, rd_valid and rd_last SHALL hold stable while rd_valid && !rd_ready.
REQ-025 On acceptance of the rd_last beat, rd_ptr SHALL advance modulo NUM_BANKS and occupancy SHALL decrement in the same cycle.
REQ-026 A commit and a release in the same cycle SHALL leave occupancy unchanged.
REQ-027 Consecutive committed banks SHALL stream back-to-back with no idle cycle when rd_ready is held high.
REQ-028 A symbol with length 1 SHALL output one beat with rd_last=1.

Reset
REQ-029 RST low SHALL clear wr_ptr, rd_ptr, occupancy, addr_err, rd_valid, rd_last, rd_data (to 0), all len[] entries and the FSM (to IDLE), at any time, including mid-symbol.
REQ-030 Bank RAM contents SHALL NOT be reset.
REQ-031 After release of RST, wr_ready SHALL be 1 and rd_valid SHALL be 0.

Configuration
REQ-032 Macro SYMBOL_BANK_ZERO_PAD_EN defined: after sample len-1, PAD SHALL emit zero samples up to index PAD_LEN-1, with rd_last on the beat at index PAD_LEN-1.
REQ-033 Macro undefined: there SHALL be no PAD state, and rd_last SHALL be asserted on the beat at index len-1.

Structure
REQ-034 A shared package sbb_pkg SHALL hold the read FSM state enum and the default parameter constants.
REQ-035 A single sub-module sbb_bank_ram (1 write port, 1 registered read port, DEPTH x DATA_WIDTH) SHALL be instantiated NUM_BANKS times.

Verification
REQ-036 Write 4 samples to addresses 0..3 (wr_last on 3), rd_ready=1 -> data out in order, rd_last on the 4th beat, occupancy 1->0.
REQ-037 NUM_BANKS=2: commit 2 symbols without reading -> wr_ready=0, occupancy=2; a third write is not accepted.
REQ-038 Toggle rd_ready 1/0 each cycle -> no sample is lost or duplicated, and rd_data is stable while stalled.
REQ-039 Write to wr_addr=1200 with DEPTH=1200 -> addr_err=1 and the memory is unchanged.
REQ-040 With SYMBOL_BANK_ZERO_PAD_EN, a len=1200 symbol -> 848 zero beats follow the data, and rd_last falls on beat 2048.
REQ-041 Assert RST mid-read -> all outputs return to 0 within the same cycle, and wr_ready=1 after release.
